// File: rtl/fifo_rr_read_arbiter.sv
// Round-robin read scheduler: picks one eligible non-empty FIFO per slot, strobes its read,
// and captures the head word plus channel tag into a single valid/ready output register.
module fifo_rr_read_arbiter #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                    ck,
  input  logic                    reset,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH-1:0]         fifo_empty,
  input  logic [N_CH*WIDTH-1:0]   fifo_data,
  output logic [N_CH-1:0]         fifo_read,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    busy
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic              state_reg, state_next;
  logic [CH_W-1:0]   last_reg;
  logic [N_CH-1:0]   cool_reg;
  logic [WIDTH-1:0]  data_reg;
  logic [CH_W-1:0]   ch_reg;

  logic [WIDTH-1:0]  word [N_CH];
  logic [N_CH-1:0]   elig;
  logic              slot;
  logic              any_elig;
  logic              grant;
  logic [CH_W-1:0]   gnt_idx;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_word
      assign word[gi] = fifo_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // A channel read last cycle still shows its old head, so it sits out one cycle.
  assign elig     = ch_en & ~fifo_empty & ~cool_reg;
  assign any_elig = |elig;
  assign slot     = (state_reg == ST_EMPTY) | out_ready;
  assign grant    = slot & any_elig & ~reset;

  always_comb begin
    logic            found;
    logic [CH_W-1:0] cand;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CH_W'((int'(last_reg) + k) % N_CH);
      if (!found && elig[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    fifo_read = '0;
    if (grant) begin
      fifo_read[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (grant) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !grant) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
      last_reg  <= CH_W'(N_CH - 1);
      cool_reg  <= '0;
      data_reg  <= '0;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cool_reg  <= fifo_read;
      if (grant) begin
        data_reg <= word[gnt_idx];
        ch_reg   <= gnt_idx;
        last_reg <= gnt_idx;
      end
    end
  end

  assign out_valid = (state_reg == ST_FULL);
  assign out_data  = data_reg;
  assign out_ch    = ch_reg;
  assign busy      = out_valid | any_elig;

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// Directed and scoreboard bench for fifo_rr_read_arbiter with a behavioural 4-channel FIFO bank.
module tb_fifo_rr_read_arbiter;

  logic        ck = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ch_en = 4'hF;
  logic [3:0]  fifo_empty = 4'hF;
  logic [31:0] fifo_data = '0;
  logic [3:0]  fifo_read;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        busy;

  logic        fifo_clr = 1'b0;
  logic [3:0]  wr_en = '0;
  logic [7:0]  wr_data [4];
  logic [7:0]  q [4][$];
  logic [7:0]  exp_q [4][$];

  int n_cmp = 0;
  int n_err = 0;

  fifo_rr_read_arbiter #(.N_CH(4), .WIDTH(8)) dut (
    .ck(ck), .reset(reset), .ch_en(ch_en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .busy(busy)
  );

  always #5 ck = ~ck;

  // FIFO bank model: head becomes visible one edge after a push or pop.
  always @(posedge ck) begin
    logic [3:0]  emp_v;
    logic [31:0] dat_v;
    for (int i = 0; i < 4; i++) begin
      if (fifo_clr) begin
        q[i].delete();
      end else begin
        if (fifo_read[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (wr_en[i]) q[i].push_back(wr_data[i]);
      end
      emp_v[i] = (q[i].size() == 0);
      dat_v[i*8 +: 8] = emp_v[i] ? 8'h00 : q[i][0];
    end
    fifo_empty <= emp_v;
    fifo_data  <= dat_v;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the sample point of the next cycle (2 time units after the edge).
  task automatic step();
    @(posedge ck);
    #2;
  endtask

  task automatic start(input logic [3:0] en, input logic rdy);
    reset    = 1'b1;
    fifo_clr = 1'b1;
    wr_en    = '0;
    ch_en    = en;
    out_ready = rdy;
    @(posedge ck);
    #1;
    fifo_clr = 1'b0;
  endtask

  task automatic push_word(input int ch, input logic [7:0] d);
    wr_en[ch]   = 1'b1;
    wr_data[ch] = d;
    @(posedge ck);
    #1;
    wr_en = '0;
  endtask

  task automatic release_rst();
    reset = 1'b0;
    #1;
  endtask

  task automatic sample_and_score();
    check("onehot_read", 32'($countones(fifo_read) <= 1), 32'd1);
    check("read_when_empty", 32'(fifo_read & fifo_empty), 32'd0);
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(exp_q[out_ch].size() != 0), 32'd1);
      if (exp_q[out_ch].size() != 0) check("sb_data", 32'(out_data), 32'(exp_q[out_ch].pop_front()));
    end
  endtask

  initial begin
    logic [3:0] rd_t2 [7];
    logic       vl_t2 [7];
    logic [7:0] dt_t2 [7];
    int         total;

    // Test 1: all channels loaded, round robin 0,1,2,3,...
    start(4'hF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) wr_data[c] = 8'(c*16 + k + 1);
      wr_en = 4'hF;
      @(posedge ck);
      #1;
      wr_en = '0;
    end
    #1;
    check("t1_rst_valid", 32'(out_valid), 32'd0);
    check("t1_rst_data", 32'(out_data), 32'd0);
    check("t1_rst_ch", 32'(out_ch), 32'd0);
    check("t1_rst_read", 32'(fifo_read), 32'd0);
    release_rst();
    check("t1_c0_read", 32'(fifo_read), 32'h1);
    check("t1_c0_valid", 32'(out_valid), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_data", 32'(out_data), 32'(((k-1)%4)*16 + (k-1)/4 + 1));
      check("t1_ch", 32'(out_ch), 32'((k-1)%4));
      check("t1_read", 32'(fifo_read), (k < 12) ? (32'd1 << (k%4)) : 32'd0);
    end
    step();
    check("t1_end_valid", 32'(out_valid), 32'd0);
    check("t1_end_busy", 32'(busy), 32'd0);
    $display("test 1 done: %0d compared", n_cmp);

    // Test 2: only ch2 holds data, reads land on alternate cycles.
    start(4'hF, 1'b1);
    push_word(2, 8'hAA);
    push_word(2, 8'hBB);
    push_word(2, 8'hCC);
    rd_t2 = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0};
    vl_t2 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    dt_t2 = '{8'h00, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC};
    release_rst();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      check("t2_read", 32'(fifo_read), 32'(rd_t2[k]));
      check("t2_valid", 32'(out_valid), 32'(vl_t2[k]));
      if (vl_t2[k]) begin
        check("t2_data", 32'(out_data), 32'(dt_t2[k]));
        check("t2_ch", 32'(out_ch), 32'd2);
      end
    end
    $display("test 2 done: %0d compared", n_cmp);

    // Test 3: stall for 5 cycles, then ch3 before ch0.
    start(4'hF, 1'b0);
    push_word(0, 8'h01);
    push_word(0, 8'h02);
    push_word(3, 8'h31);
    push_word(3, 8'h32);
    release_rst();
    check("t3_c0_read", 32'(fifo_read), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t3_stall_valid", 32'(out_valid), 32'd1);
      check("t3_stall_data", 32'(out_data), 32'h01);
      check("t3_stall_read", 32'(fifo_read), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("t3_rel_read", 32'(fifo_read), 32'h8);
    step();
    check("t3_d1", {out_ch, out_data}, {2'd3, 8'h31});
    check("t3_r1", 32'(fifo_read), 32'h1);
    step();
    check("t3_d2", {out_ch, out_data}, {2'd0, 8'h02});
    check("t3_r2", 32'(fifo_read), 32'h8);
    step();
    check("t3_d3", {out_ch, out_data}, {2'd3, 8'h32});
    check("t3_r3", 32'(fifo_read), 32'h0);
    $display("test 3 done: %0d compared", n_cmp);

    // Test 4: mask 1010 keeps ch0/ch2 out of the rotation.
    start(4'b1010, 1'b1);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) wr_data[c] = 8'(c*16 + k + 1);
      wr_en = 4'hF;
      @(posedge ck);
      #1;
      wr_en = '0;
    end
    release_rst();
    check("t4_c0_read", 32'(fifo_read), 32'h2);
    step();
    check("t4_d1", {out_ch, out_data}, {2'd1, 8'h11});
    check("t4_r1", 32'(fifo_read), 32'h8);
    step();
    check("t4_d2", {out_ch, out_data}, {2'd3, 8'h31});
    check("t4_r2", 32'(fifo_read), 32'h2);
    step();
    check("t4_d3", {out_ch, out_data}, {2'd1, 8'h12});
    check("t4_r3", 32'(fifo_read), 32'h8);
    step();
    check("t4_d4", {out_ch, out_data}, {2'd3, 8'h32});
    check("t4_r4", 32'(fifo_read), 32'h0);
    step();
    check("t4_end_valid", 32'(out_valid), 32'd0);
    check("t4_end_busy", 32'(busy), 32'd0);
    $display("test 4 done: %0d compared", n_cmp);

    // Test 5: async reset while holding a word.
    start(4'hF, 1'b0);
    push_word(0, 8'h61);
    push_word(0, 8'h62);
    push_word(1, 8'h71);
    release_rst();
    step();
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    check("t5_pre_data", 32'(out_data), 32'h61);
    reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_data", 32'(out_data), 32'd0);
    check("t5_async_read", 32'(fifo_read), 32'd0);
    step();
    check("t5_hold_read", 32'(fifo_read), 32'd0);
    out_ready = 1'b1;
    release_rst();
    check("t5_rel_read", 32'(fifo_read), 32'h1);
    step();
    check("t5_d1", {out_ch, out_data}, {2'd0, 8'h62});
    check("t5_r1", 32'(fifo_read), 32'h2);
    $display("test 5 done: %0d compared", n_cmp);

    // Test 6: random writes and backpressure against a per-channel scoreboard.
    start(4'hF, 1'b1);
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    release_rst();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge ck);
      #1;
      for (int c = 0; c < 4; c++) begin
        wr_en[c] = ($urandom_range(0, 99) < 30) && (exp_q[c].size() < 16);
        wr_data[c] = 8'($urandom_range(0, 255));
        if (wr_en[c]) exp_q[c].push_back(wr_data[c]);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      if (cyc % 64 == 0) ch_en = 4'($urandom_range(0, 15));
      #1;
      sample_and_score();
    end
    @(posedge ck);
    #1;
    wr_en = '0;
    ch_en = 4'hF;
    out_ready = 1'b1;
    #1;
    sample_and_score();
    for (int cyc = 0; cyc < 300; cyc++) begin
      total = 0;
      for (int c = 0; c < 4; c++) total += exp_q[c].size();
      if (total == 0 && !out_valid) break;
      step();
      sample_and_score();
    end
    total = 0;
    for (int c = 0; c < 4; c++) total += exp_q[c].size();
    check("t6_drain_left", 32'(total), 32'd0);
    check("t6_drain_valid", 32'(out_valid), 32'd0);
    $display("test 6 done: %0d compared", n_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
